// File: rtl/pmod_frame_receiver.sv
// pmod_frame_receiver
//   Receiver for the 3-wire PMOD serial link (cs_n active low, sdata, sclk).
//   The link is oversampled with CLK. Each frame is rebuilt into a parallel word.
//   The word is offered on a valid/ready interface.
//   Frames whose bit count is not WIDTH are flagged with frame_err.
//
// Ports
//   CLK         system clock (sclk must be at most CLK/8)
//   RST         asynchronous active-high reset
//   cs_n        link chip select, active low, asynchronous
//   sdata       link data, asynchronous
//   sclk        link serial clock, asynchronous
//   dout        received word, held stable while dout_valid is high
//   dout_valid  dout holds an unconsumed word
//   dout_ready  consumer accepts dout
//   frame_err   one-cycle pulse on a frame with a bad bit count
//   overrun     sticky: a good frame was dropped because dout_valid was high
//   busy        high while a frame is being shifted in
//   good_cnt    (PMOD_RX_STATS_EN only) count of good frames, wraps
//   err_cnt     (PMOD_RX_STATS_EN only) count of frame_err pulses, wraps
//
// Optional feature macro: PMOD_RX_STATS_EN
module pmod_frame_receiver #(
    parameter int WIDTH          = 16,
    parameter int LSB_FIRST      = 1,
    parameter int SAMPLE_ON_FALL = 1,
    parameter int SYNC_STAGES    = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             cs_n,
    input  logic             sdata,
    input  logic             sclk,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             frame_err,
    output logic             overrun,
`ifdef PMOD_RX_STATS_EN
    output logic [15:0]      good_cnt,
    output logic [15:0]      err_cnt,
`endif
    output logic             busy
);

    localparam int CW = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {ARM, IDLE, SHIFT, CHECK} state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] cs_sync, sd_sync, sck_sync;
    logic                   cs_dly, sck_dly;
    logic                   cs_rise_p1, cs_fall_p1, sck_edge_p1, sd_p1;
    logic                   cs_lvl, sck_lvl;

    logic [WIDTH-1:0]       shreg;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          shamt;
    logic [WIDTH-1:0]       mask;
    logic                   start, capture, in_check, good;

    assign cs_lvl  = cs_sync[SYNC_STAGES-1];
    assign sck_lvl = sck_sync[SYNC_STAGES-1];

    // Synchroniser stage: the chains reset to 0 so that a cs_n that is
    // still low at reset release looks like a frame in flight and is
    // discarded by ARM rather than seen as a fresh falling edge.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cs_sync     <= '0;
            sd_sync     <= '0;
            sck_sync    <= '0;
            cs_dly      <= 1'b0;
            sck_dly     <= 1'b0;
            cs_rise_p1  <= 1'b0;
            cs_fall_p1  <= 1'b0;
            sck_edge_p1 <= 1'b0;
            sd_p1       <= 1'b0;
        end else begin
            cs_sync     <= {cs_sync[SYNC_STAGES-2:0], cs_n};
            sd_sync     <= {sd_sync[SYNC_STAGES-2:0], sdata};
            sck_sync    <= {sck_sync[SYNC_STAGES-2:0], sclk};
            cs_dly      <= cs_lvl;
            sck_dly     <= sck_lvl;
            cs_rise_p1  <= cs_lvl & ~cs_dly;
            cs_fall_p1  <= ~cs_lvl & cs_dly;
            sck_edge_p1 <= (SAMPLE_ON_FALL != 0) ? (~sck_lvl & sck_dly)
                                                 : (sck_lvl & ~sck_dly);
            // registered alongside the edge pulse so data stays aligned
            sd_p1       <= sd_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= ARM;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        start    = 1'b0;
        capture  = 1'b0;
        in_check = 1'b0;
        case (state_q)
            ARM:   if (cs_lvl) state_d = IDLE;
            IDLE:  if (cs_fall_p1) begin
                       start   = 1'b1;
                       state_d = SHIFT;
                   end
            SHIFT: begin
                       // a sample edge in the same cycle as cs_n rising is
                       // still captured before the frame is checked
                       capture = sck_edge_p1;
                       if (cs_rise_p1) state_d = CHECK;
                   end
            CHECK: begin
                       in_check = 1'b1;
                       state_d  = IDLE;
                   end
            default: state_d = ARM;
        endcase
    end

    assign good  = in_check && (cnt == CW'(WIDTH));
    assign busy  = (state_q == SHIFT);
    assign shamt = (LSB_FIRST != 0) ? cnt : (CW'(WIDTH - 1) - cnt);
    assign mask  = {{(WIDTH-1){1'b0}}, 1'b1} << shamt;

    // Shift / output stage
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            shreg      <= '0;
            cnt        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err <= in_check & ~good;

            if (start) begin
                shreg <= '0;
                cnt   <= '0;
            end else if (capture) begin
                // bits beyond WIDTH only matter for the count
                if (cnt < CW'(WIDTH))
                    shreg <= sd_p1 ? (shreg | mask) : (shreg & ~mask);
                if (cnt != CW'(WIDTH + 1))
                    cnt <= cnt + 1'b1;
            end

            // a handshake in the CHECK cycle frees dout for the new word
            if (good && (!dout_valid || dout_ready)) begin
                dout       <= shreg;
                dout_valid <= 1'b1;
            end else begin
                if (good)
                    overrun <= 1'b1;
                if (dout_valid && dout_ready)
                    dout_valid <= 1'b0;
            end
        end
    end

`ifdef PMOD_RX_STATS_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            good_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (good)
                good_cnt <= good_cnt + 16'd1;
            if (in_check && !good)
                err_cnt <= err_cnt + 16'd1;
        end
    end
`endif

endmodule
